// File: rtl/wb_pwm_pkg.sv
// rtl/wb_pwm_pkg.sv - Register map, bit positions and defaults for the wb_pwm PWM generator
package wb_pwm_pkg;
  localparam int NCH_DEF   = 2;
  localparam int CNT_W_DEF = 16;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_PRESCALE = 3'd2;
  localparam logic [2:0] REG_PERIOD   = 3'd3;
  localparam logic [2:0] REG_DUTY0    = 3'd4;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_IE       = 1;
  localparam int CTRL_STEP_LSB = 8;
  localparam int STATUS_PEF    = 0;
  localparam int STATUS_RAMP   = 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} pwm_state_e;

  // Only byte lanes 0 and 1 are writable; lanes 2-3 never reach a register.
  function automatic logic [15:0] lane_merge(input logic [15:0] old, input logic [31:0] dat,
                                             input logic [3:0] sel);
    lane_merge = old;
    if (sel[0]) lane_merge[7:0] = dat[7:0];
    if (sel[1]) lane_merge[15:8] = dat[15:8];
  endfunction
endpackage

// File: rtl/wb_pwm_if.sv
// rtl/wb_pwm_if.sv - Wishbone slave bundle for wb_pwm
interface wb_pwm_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o;

  modport slave (input wb_adr_i, wb_dat_i, wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i,
                 output wb_dat_o, wb_ack_o);
  modport master (output wb_adr_i, wb_dat_i, wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i,
                  input wb_dat_o, wb_ack_o);
endinterface

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - One PWM channel: staging/active duty, compare register,
// ramp-limited duty loading when WB_PWM_SOFTSTART_EN is defined
module pwm_channel
  import wb_pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_run,
  input  logic             i_wrap,
  input  logic             i_we,
  input  logic [31:0]      i_dat,
  input  logic [3:0]       i_sel,
  input  logic [CNT_W-1:0] i_cnt,
`ifdef WB_PWM_SOFTSTART_EN
  input  logic [7:0]       i_step,
  output logic             o_ramp,
`endif
  output logic [CNT_W-1:0] o_stg,
  output logic             o_pwm
);
  logic [CNT_W-1:0] r_stg, r_act, w_act_nxt;
  logic             r_pwm;

`ifdef WB_PWM_SOFTSTART_EN
  logic [CNT_W-1:0] w_step;
  assign w_step = CNT_W'(i_step);

  // Move toward staging by at most one step per wrap, landing exactly on it.
  always_comb begin
    w_act_nxt = r_stg;
    if (w_step != '0) begin
      if (r_act < r_stg && (r_stg - r_act) > w_step)      w_act_nxt = r_act + w_step;
      else if (r_act > r_stg && (r_act - r_stg) > w_step) w_act_nxt = r_act - w_step;
    end
  end
  assign o_ramp = (r_act != r_stg);
`else
  assign w_act_nxt = r_stg;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stg <= '0;
      r_act <= '0;
      r_pwm <= 1'b0;
    end else begin
      if (i_we) r_stg <= CNT_W'(lane_merge(16'(r_stg), i_dat, i_sel));
      if (!i_run)      r_act <= r_stg;
      else if (i_wrap) r_act <= w_act_nxt;
      r_pwm <= i_run & (i_cnt < r_act);
    end
  end

  assign o_stg = r_stg;
  assign o_pwm = r_pwm;
endmodule

// File: rtl/wb_pwm.sv
// rtl/wb_pwm.sv - Wishbone PWM generator: prescaler, shared period, per-channel duty, period-end irq
// Optional soft-start duty ramp enabled by defining WB_PWM_SOFTSTART_EN.
module wb_pwm
  import wb_pwm_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  wb_pwm_if.slave        wb,
  output logic           intr,
  output logic [NCH-1:0] pwm_o
);
  pwm_state_e       r_state, w_state_nxt;
  logic             r_ack, r_ie, r_pef, r_intr;
  logic [CNT_W-1:0] r_prescale, r_period_stg, r_period_act, r_pre, r_cnt;
  logic [CNT_W-1:0] w_duty_stg [NCH];
  logic [7:0]       w_step;
  logic [2:0]       w_idx;
  logic [31:0]      w_rd;
  logic             w_req, w_wr, w_run, w_tick, w_wrap, w_pef_clr, w_ramp, w_unused;

  assign w_idx     = wb.wb_adr_i[4:2];
  assign w_req     = wb.wb_stb_i & wb.wb_cyc_i;
  assign w_wr      = r_ack & w_req & wb.wb_we_i;
  assign w_run     = (r_state == ST_RUN);
  assign w_tick    = w_run & (r_pre >= r_prescale);
  assign w_wrap    = w_tick & (r_cnt >= r_period_act);
  assign w_pef_clr = w_wr & (w_idx == REG_STATUS) & wb.wb_sel_i[0] & wb.wb_dat_i[STATUS_PEF];
  assign w_unused  = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0]};

  // EN is the state register itself, so a CTRL write changes mode on the very next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_wr && w_idx == REG_CTRL && wb.wb_sel_i[0])
      w_state_nxt = wb.wb_dat_i[CTRL_EN] ? ST_RUN : ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack        <= 1'b0;
      r_ie         <= 1'b0;
      r_prescale   <= '0;
      r_period_stg <= '0;
    end else begin
      r_ack <= w_req & ~r_ack;
      if (w_wr) begin
        case (w_idx)
          REG_CTRL:     if (wb.wb_sel_i[0]) r_ie <= wb.wb_dat_i[CTRL_IE];
          REG_PRESCALE: r_prescale <= CNT_W'(lane_merge(16'(r_prescale), wb.wb_dat_i, wb.wb_sel_i));
          REG_PERIOD:   r_period_stg <= CNT_W'(lane_merge(16'(r_period_stg), wb.wb_dat_i, wb.wb_sel_i));
          default: ;
        endcase
      end
    end
  end

`ifdef WB_PWM_SOFTSTART_EN
  logic [7:0]     r_step;
  logic [NCH-1:0] w_ramp_vec;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                             r_step <= '0;
    else if (w_wr && w_idx == REG_CTRL && wb.wb_sel_i[1]) r_step <= wb.wb_dat_i[15:8];
  end
  assign w_step = r_step;
  assign w_ramp = |w_ramp_vec;
`else
  assign w_step = '0;
  assign w_ramp = 1'b0;
`endif

  // The prescaler free-runs across period wraps; only IDLE clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre        <= '0;
      r_cnt        <= '0;
      r_period_act <= '0;
    end else if (!w_run) begin
      r_pre        <= '0;
      r_cnt        <= '0;
      r_period_act <= r_period_stg;
    end else if (w_tick) begin
      r_pre <= '0;
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) r_period_act <= r_period_stg;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pef  <= 1'b0;
      r_intr <= 1'b0;
    end else begin
      if (w_wrap)         r_pef <= 1'b1;
      else if (w_pef_clr) r_pef <= 1'b0;
      r_intr <= r_pef & r_ie;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .i_run  (w_run),
      .i_wrap (w_wrap),
      .i_we   (w_wr && (w_idx == REG_DUTY0 + 3'(k))),
      .i_dat  (wb.wb_dat_i),
      .i_sel  (wb.wb_sel_i),
      .i_cnt  (r_cnt),
`ifdef WB_PWM_SOFTSTART_EN
      .i_step (w_step),
      .o_ramp (w_ramp_vec[k]),
`endif
      .o_stg  (w_duty_stg[k]),
      .o_pwm  (pwm_o[k])
    );
  end

  always_comb begin
    w_rd = '0;
    case (w_idx)
      REG_CTRL: begin
        w_rd[CTRL_EN]              = w_run;
        w_rd[CTRL_IE]              = r_ie;
        w_rd[CTRL_STEP_LSB +: 8]   = w_step;
      end
      REG_STATUS: begin
        w_rd[STATUS_PEF]  = r_pef;
        w_rd[STATUS_RAMP] = w_ramp;
      end
      REG_PRESCALE: w_rd[CNT_W-1:0] = r_prescale;
      REG_PERIOD:   w_rd[CNT_W-1:0] = r_period_stg;
      default: begin
        for (int k = 0; k < NCH; k++)
          if (w_idx == REG_DUTY0 + 3'(k)) w_rd[CNT_W-1:0] = w_duty_stg[k];
      end
    endcase
  end

  assign wb.wb_dat_o = r_ack ? w_rd : 32'd0;
  assign wb.wb_ack_o = r_ack;
  assign intr        = r_intr;
endmodule

// File: tb/tb_wb_pwm.sv
// tb/tb_wb_pwm.sv - Self-checking bench for wb_pwm against a period-arithmetic reference model
module tb_wb_pwm;
  import wb_pwm_pkg::*;
  localparam int NCH = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           intr;
  logic [NCH-1:0] pwm_o;

  wb_pwm_if wbi();
  wb_pwm #(.NCH(NCH), .CNT_W(16)) dut (.clk(clk), .rst(rst), .wb(wbi), .intr(intr), .pwm_o(pwm_o));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: run cycle m counts from 1 (first cycle with EN=1).
  int ps, per, ie, step, base;
  int dinit [NCH];
  int wr_mv[$], wr_ch[$], wr_val[$];
  bit chk_on = 0, chk_intr = 0;

  function automatic int stg_at(int ch, int mw);
    int v;
    v = dinit[ch];
    foreach (wr_mv[i]) if (wr_ch[i] == ch && wr_mv[i] <= mw) v = wr_val[i];
    return v;
  endfunction

  // Active duty during period p: staging as seen in the wrap cycle closing period p-1.
  function automatic int act_for(int ch, int p);
    int a;
    a = stg_at(ch, 0);
`ifdef WB_PWM_SOFTSTART_EN
    for (int q = 1; q <= p; q++) begin
      int s;
      s = stg_at(ch, q * (per + 1) * (ps + 1));
      if (step == 0)  a = s;
      else if (a < s) a = (s - a > step) ? a + step : s;
      else            a = (a - s > step) ? a - step : s;
    end
`else
    if (p > 0) a = stg_at(ch, p * (per + 1) * (ps + 1));
`endif
    return a;
  endfunction

  function automatic bit exp_pwm(int ch, int m);
    int c, t, cn, p;
    if (m < 2) return 1'b0;
    c  = m - 1;
    t  = (c - 1) / (ps + 1);
    cn = t % (per + 1);
    p  = t / (per + 1);
    return cn < act_for(ch, p);
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      int m;
      m = cyc - base;
      for (int k = 0; k < NCH; k++) check($sformatf("pwm%0d@m%0d", k, m), pwm_o[k], exp_pwm(k, m));
      if (chk_intr) check($sformatf("intr@m%0d", m), intr, (ie != 0 && m >= (per + 1) * (ps + 1) + 2));
    end
  end

  function automatic logic [31:0] ra(int idx);
    return 32'h7000_0000 | 32'(idx << 2);
  endfunction

  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [3:0] sel, output logic [31:0] rdat);
    @(negedge clk);
    wbi.wb_adr_i = adr; wbi.wb_dat_i = wdat; wbi.wb_sel_i = sel; wbi.wb_we_i = we;
    wbi.wb_stb_i = 1'b1; wbi.wb_cyc_i = 1'b1;
    @(negedge clk);
    check("ack_1clk", wbi.wb_ack_o, 1'b1);
    rdat = wbi.wb_dat_o;
    @(posedge clk); #1;
    wbi.wb_stb_i = 1'b0; wbi.wb_cyc_i = 1'b0; wbi.wb_we_i = 1'b0;
    check("ack_single", wbi.wb_ack_o, 1'b0);
    check("dat_idle0", wbi.wb_dat_o, 32'd0);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, d, 4'hF, dummy);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] d);
    wb_xfer(1'b0, adr, 32'd0, 4'hF, d);
  endtask

  task automatic wait_m(input int target);
    for (int i = 0; i < 10000 && (cyc - base) < target; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic cfg(input int p_ps, input int p_per, input int d0, input int d1);
    ps = p_ps; per = p_per; dinit[0] = d0; dinit[1] = d1;
    wr_mv.delete(); wr_ch.delete(); wr_val.delete();
    wr(ra(2), 32'(p_ps)); wr(ra(3), 32'(p_per)); wr(ra(4), 32'(d0)); wr(ra(5), 32'(d1));
  endtask

  task automatic wr_duty(input int ch, input int v);
    wr(ra(4 + ch), 32'(v));
    wr_mv.push_back(cyc - base); wr_ch.push_back(ch); wr_val.push_back(v);
  endtask

  task automatic start_run(input int p_ie);
    ie = p_ie;
    wr(ra(0), 32'(1 | (p_ie << 1) | (step << 8)));
    base = cyc - 1;
    chk_on = 1'b1; chk_intr = 1'b1;
  endtask

  task automatic stop_run();
    chk_on = 1'b0; chk_intr = 1'b0;
    wr(ra(0), 32'd0);
    wr(ra(1), 32'd1);
    step = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] rv;
    int lim, m_w;
    step = 0; base = 0; ps = 0; per = 0; ie = 0;
    wbi.wb_adr_i = '0; wbi.wb_dat_i = '0; wbi.wb_sel_i = '0;
    wbi.wb_we_i = 1'b0; wbi.wb_stb_i = 1'b0; wbi.wb_cyc_i = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_pwm", pwm_o, 0);
    check("rst_intr", intr, 0);
    check("rst_ack", wbi.wb_ack_o, 0);
    check("rst_dat", wbi.wb_dat_o, 0);
    rst = 1'b1;

    wr(ra(3), 32'hFFFF_0009); rd(ra(3), rv); check("period_rb", rv, 32'd9);
    rd(ra(7), rv); check("adr1c_rd", rv, 0);
    wr(ra(7), 32'h55); rd(ra(7), rv); check("adr1c_wr", rv, 0);
    wr(ra(2), 32'hABCD);
    wb_xfer(1'b1, ra(2), 32'h1234, 4'b0001, rv);
    rd(ra(2), rv); check("sel_lane0", rv, 32'hAB34);
    wr(ra(0), 32'h0500); rd(ra(0), rv);
`ifdef WB_PWM_SOFTSTART_EN
    check("ctrl_step", rv, 32'h0500);
`else
    check("ctrl_step", rv, 32'h0);
`endif
    wr(ra(0), 32'd0);

    // Basic PWM plus DUTY1 above the period (constant high).
    cfg(0, 9, 3, 10); start_run(0); wait_m(45); stop_run();
    // Duty 0 and prescale stretching.
    cfg(3, 9, 0, 5);  start_run(0); wait_m(100); stop_run();

    // Double buffering: mid-period write at cnt=5, then a write landing on the wrap cycle.
    cfg(0, 9, 3, 0); start_run(1);
    wait_m(15); wr_duty(0, 7);
    wait_m(39); wr_duty(0, 2);

    // Interrupt clear off-wrap, rise timing, clear on a wrap, and masking.
    chk_intr = 1'b0;
    wait_m(73); wr(ra(1), 32'd1);
    rd(ra(1), rv);
    check("pef_cleared", rv[0], 1'b0);
    check("ramp_idle", rv[1], 1'b0);
    check("intr_cleared", intr, 1'b0);
    wait_m(81);
    @(negedge clk); check("intr_before", intr, 1'b0);
    @(negedge clk); check("intr_rise", intr, 1'b1);
    wait_m(89); wr(ra(1), 32'd1);
    rd(ra(1), rv); check("pef_set_wins", rv[0], 1'b1);
    wr(ra(0), 32'd1);
    repeat (2) @(negedge clk);
    check("intr_masked", intr, 1'b0);
    rd(ra(1), rv); check("pef_masked", rv[0], 1'b1);
    stop_run();

    // Randomized configurations with one mid-run staging write each.
    for (int it = 0; it < 6; it++) begin
      cfg($urandom_range(0, 3), $urandom_range(0, 12), 0, 0);
      dinit[0] = $urandom_range(0, per + 2); dinit[1] = $urandom_range(0, per + 2);
      wr(ra(4), 32'(dinit[0])); wr(ra(5), 32'(dinit[1]));
      start_run($urandom_range(0, 1));
      lim = (per + 1) * (ps + 1) * 3 + 10;
      wait_m($urandom_range(3, lim - 8));
      wr_duty($urandom_range(0, NCH - 1), $urandom_range(0, per + 2));
      wait_m(lim);
      stop_run();
    end

    // Soft-start ramp 0 -> 7 with STEP=2 (direct load when the feature is absent).
    cfg(0, 9, 0, 0); step = 2; start_run(0);
    wait_m(2); wr_duty(0, 7);
    wait_m(14); rd(ra(1), rv);
`ifdef WB_PWM_SOFTSTART_EN
    check("ramping_on", rv[1], 1'b1);
`else
    check("ramping_on", rv[1], 1'b0);
`endif
    wait_m(50); rd(ra(1), rv); check("ramping_done", rv[1], 1'b0);
    stop_run();

    // Asynchronous reset while outputs are high.
    cfg(0, 9, 10, 10); start_run(1); wait_m(20);
    chk_on = 1'b0;
    m_w = 0;
    @(negedge clk); check("pre_rst_pwm", pwm_o, 2'b11);
    #2 rst = 1'b0;
    #1;
    check("async_pwm", pwm_o, 0);
    check("async_intr", intr, 0);
    check("async_ack", wbi.wb_ack_o, m_w);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_pwm.md
Name: wb_pwm

Overview:
- Wishbone slave PWM generator for the dryer heater and fan drive.
- Sits on a free conbus slave slot (0x70000000) beside timer0 and gpio0.
- Programmable prescaler, shared period, per-channel duty.
- Period/duty writes are double-buffered and only take effect at period wrap; a period-end interrupt goes to the LM32 interrupt vector.

Parameters:
- NCH, 2, number of PWM channels (1..4).
- CNT_W, 16, width of prescaler, period, duty and counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- wb_adr_i  in  32  byte address; only wb_adr_i[4:2] is decoded
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_we_i  in  1  write enable
- wb_sel_i  in  4  byte lanes; lanes 0-1 honoured, lanes 2-3 ignored
- wb_ack_o  out  1  acknowledge
- intr  out  1  period-end interrupt, active-high level
- pwm_o  out  NCH  PWM outputs, active-high

Behaviour:
- Reset (rst=0, async) clears all registers, counters, flags and shadows. Outputs reset to: wb_ack_o=0, wb_dat_o=0, intr=0, pwm_o=0.
- Register map (adr[4:2]):
  - 0 CTRL: bit0 EN, bit1 IE.
  - 1 STATUS: bit0 PEF (period-end flag); writing 1 clears it.
  - 2 PRESCALE.
  - 3 PERIOD.
  - 4+k DUTYk staging register, k < NCH.
  - All other addresses read 0 and ignore writes.
- Bus handshake:
  - wb_ack_o is registered: it rises on the cycle after stb&cyc&~ack and stays high for one cycle. Back-to-back accesses therefore take 2 cycles each.
  - A write commits on the ack cycle.
  - wb_dat_o is valid while ack is high and 0 otherwise.
  - Reads of PERIOD and DUTY return the staging value, not the active value.
- Tick generation: the prescale counter counts 0..PRESCALE and a tick is emitted on its wrap. PRESCALE=0 gives a tick every clock.
- Main counter, two states:
  - IDLE (EN=0):
    - counters are held at 0 and pwm_o=0;
    - staging values copy to active every cycle.
  - RUN (EN=1), on each tick:
    - cnt increments and wraps from PERIOD to 0;
    - on wrap: active period/duty load from staging, PEF is set, and the prescale counter does not reset.
  - IDLE->RUN on EN 0->1, with the first tick PRESCALE+1 clocks later. RUN->IDLE on EN 1->0, taking effect on the next cycle.
- Output rule: pwm_o[k] is registered and equals (cnt < duty_act[k]), so latency is 1 clk from the counter.
  - duty 0 gives constant 0.
  - duty >= PERIOD+1 gives constant 1.
  - PERIOD=0 gives a 1-tick period.
- intr = PEF & IE, registered.
- Simultaneous events:
  - A software clear of PEF in the same cycle as a wrap: set wins.
  - A staging write in the same cycle as a wrap: the active register loads the old staging value and the new value applies at the next wrap.
- Reset mid-period forces all outputs low within the same cycle (async).

Optional Feature:
- Macro WB_PWM_SOFTSTART_EN.
- When defined:
  - at each wrap, duty_act[k] moves toward staging by at most STEP (CTRL[15:8], 0 = no limit), with no overshoot;
  - PEF is still set on every wrap;
  - STATUS bit1 RAMPING = 1 while any channel's active value differs from its staging value.
- When undefined: duty loads directly at wrap, CTRL[15:8] reads 0, and STATUS bit1 reads 0.
- In IDLE both builds copy directly.

Decomposition:
- Package wb_pwm_pkg:
  - register index constants (REG_CTRL=0 .. REG_DUTY0=4);
  - CTRL/STATUS bit positions;
  - localparams for CNT_W defaults.
- Sub-module pwm_channel (one per channel, via generate): holds staging/active duty, soft-start step logic and the output compare register.

Test Plan:
- Reset/bus: hold rst=0, check pwm_o=0 and intr=0. Write PERIOD=9 and read it back 9. Check ack lasts exactly 1 cycle, 1 clk after stb. Reading adr 0x1C returns 0.
- Basic PWM: PRESCALE=0, PERIOD=9, DUTY0=3, EN=1. pwm_o[0] must be high 3 clks and low 7, repeating every 10 clks, with 1-clk latency after cnt=0.
- Edge duties: DUTY0=0 gives pwm_o[0] constantly 0. DUTY1=10 with PERIOD=9 gives pwm_o[1] constantly 1. PRESCALE=3 stretches each level by 4×.
- Double buffering: while running DUTY0=3, write DUTY0=7 mid-period at cnt=5. The current period stays 3 high and the next period is 7 high. Also cover a write coinciding with the wrap cycle.
- Interrupt: IE=1, and intr rises 1 clk after the wrap. Writing STATUS=1 clears it; a clear on a wrap cycle leaves PEF=1. With IE=0, intr stays 0 while PEF=1.
- Soft-start (macro on): STEP=2, duty 0->7 gives active values 2,4,6,7 across 4 periods with RAMPING=1 until 7. With the macro off, 7 applies at the first wrap.
